fetch_stage: RTL and testbench

Instruction-fetch stage of the ARM pipeline, directly upstream of the decode stage. Holds the program counter and fetches one instruction per request over a single-outstanding instruction-memory handshake. Applies branch redirects and flushes from the execute stage and freezes on decode hazards or SRAM stalls. Drives the registered IF/ID outputs: PC+4, instruction and valid.

---
 rtl/fetch_stage.sv | 184 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. It holds the PC, issues one outstanding
// instruction-memory read at a time, applies branch redirects from execute,
// freezes on decode hazards, and drives the registered IF/ID outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // FETCH: request at pc; HOLD: completed fetch parked while decode is frozen;
    // DISCARD: a request abandoned by a branch is still open and must be drained.
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] kill_addr;
    logic [XLEN-1:0] kill_addr_next;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_instr_next;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_pc_next;
    logic [XLEN-1:0] pc_out_next;
    logic [XLEN-1:0] instr_out_next;
    logic            valid_out_next;

    logic            done;
    logic            bubble;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_target;

    // Redirect targets are word aligned; the low address bits are deliberately ignored.
    logic unused_branch_lsbs;
    assign unused_branch_lsbs = &{1'b0, branch_addr[1:0]};

    assign pc_plus4      = pc + PC_STEP;
    assign branch_target = {branch_addr[XLEN-1:2], 2'b00};

    // Memory handshake is driven from registers only, never from imem_ready.
    assign imem_req  = !rst && ((state == FETCH) || (state == DISCARD));
    assign imem_addr = (state == DISCARD) ? kill_addr : pc;
    assign done      = imem_req && imem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: branch beats freeze beats normal progress.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (branch_taken) begin
                    state_next = done ? FETCH : DISCARD;
                end else if (done && freeze) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (branch_taken || !freeze) begin
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                if (done) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Datapath next values: PC, kill address, freeze buffer and IF/ID outputs.
    always_comb begin
        pc_next         = pc;
        kill_addr_next  = kill_addr;
        hold_instr_next = hold_instr;
        hold_pc_next    = hold_pc;
        pc_out_next     = pc_out;
        instr_out_next  = instruction_out;
        valid_out_next  = valid_out;
        bubble          = 1'b0;

        case (state)
            FETCH: begin
                if (branch_taken) begin
                    // Completed data is dropped; an open request is drained in DISCARD.
                    pc_next = branch_target;
                    bubble  = 1'b1;
                    if (!done) begin
                        kill_addr_next = pc;
                    end
                end else if (done) begin
                    pc_next = pc_plus4;
                    if (freeze) begin
                        hold_instr_next = imem_rdata;
                        hold_pc_next    = pc_plus4;
                    end else begin
                        instr_out_next = imem_rdata;
                        pc_out_next    = pc_plus4;
                        valid_out_next = 1'b1;
                    end
                end else if (!freeze) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_next = branch_target;
                    bubble  = 1'b1;
                end else if (!freeze) begin
                    instr_out_next = hold_instr;
                    pc_out_next    = hold_pc;
                    valid_out_next = 1'b1;
                end
            end
            DISCARD: begin
                // Latest redirect wins; the drained data is never forwarded.
                if (branch_taken) begin
                    pc_next = branch_target;
                    bubble  = 1'b1;
                end else if (!freeze) begin
                    bubble = 1'b1;
                end
            end
            default: begin
                bubble = 1'b1;
            end
        endcase

        if (bubble) begin
            instr_out_next = '0;
            pc_out_next    = '0;
            valid_out_next = 1'b0;
        end
    end

    // Datapath and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_PC;
            kill_addr       <= '0;
            hold_instr      <= '0;
            hold_pc         <= '0;
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else begin
            pc              <= pc_next;
            kill_addr       <= kill_addr_next;
            hold_instr      <= hold_instr_next;
            hold_pc         <= hold_pc_next;
            pc_out          <= pc_out_next;
            instruction_out <= instr_out_next;
            valid_out       <= valid_out_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: two fetch_stage instances (reset PC 0 and 0xFFFF_FFFC) driven by
// shared directed and random stimulus, checked every cycle against a
// transaction-level model, plus literal expectations for the directed scenarios.
module tb_fetch_stage;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_ready;

    logic        imem_req        [NI];
    logic [31:0] imem_addr       [NI];
    logic [31:0] imem_rdata      [NI];
    logic [31:0] pc_out          [NI];
    logic [31:0] instruction_out [NI];
    logic        valid_out       [NI];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory image: word n holds n + 0x100.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    function automatic logic [31:0] reset_pc(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    assign imem_rdata[0] = mem_word(imem_addr[0]);
    assign imem_rdata[1] = mem_word(imem_addr[1]);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req[0]), .imem_addr(imem_addr[0]),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata[0]),
        .pc_out(pc_out[0]), .instruction_out(instruction_out[0]),
        .valid_out(valid_out[0])
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req[1]), .imem_addr(imem_addr[1]),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata[1]),
        .pc_out(pc_out[1]), .instruction_out(instruction_out[1]),
        .valid_out(valid_out[1])
    );

    // Model: next fetch pc, an optional abandoned request still to be drained,
    // an optional parked instruction, and what decode currently sees.
    logic [31:0] m_pc     [NI] = '{32'h0, 32'h0};
    logic [31:0] m_kill   [NI] = '{32'h0, 32'h0};
    bit          m_pend   [NI] = '{1'b0, 1'b0};
    bit          m_buf    [NI] = '{1'b0, 1'b0};
    logic [31:0] m_buf_i  [NI] = '{32'h0, 32'h0};
    logic [31:0] m_buf_pc [NI] = '{32'h0, 32'h0};
    bit          m_val    [NI] = '{1'b0, 1'b0};
    logic [31:0] m_out_i  [NI] = '{32'h0, 32'h0};
    logic [31:0] m_out_pc [NI] = '{32'h0, 32'h0};

    logic        obs_req  [NI];
    logic [31:0] obs_addr [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_bubble(input int i);
        m_val[i]    = 1'b0;
        m_out_i[i]  = 32'h0;
        m_out_pc[i] = 32'h0;
    endtask

    // Advance the model over one edge using the inputs currently applied.
    task automatic model_step(input int i);
        logic [31:0] tgt;
        bit done;
        tgt  = {branch_addr[31:2], 2'b00};
        done = !rst && !m_buf[i] && imem_ready;
        if (rst) begin
            m_pc[i] = reset_pc(i); m_kill[i] = 32'h0; m_pend[i] = 1'b0;
            m_buf[i] = 1'b0; m_buf_i[i] = 32'h0; m_buf_pc[i] = 32'h0;
            m_bubble(i);
        end else if (m_buf[i]) begin
            if (branch_taken) begin
                m_buf[i] = 1'b0; m_pc[i] = tgt; m_bubble(i);
            end else if (!freeze) begin
                m_buf[i] = 1'b0; m_val[i] = 1'b1;
                m_out_i[i] = m_buf_i[i]; m_out_pc[i] = m_buf_pc[i];
            end
        end else if (m_pend[i]) begin
            if (done) m_pend[i] = 1'b0;
            if (branch_taken) begin
                m_pc[i] = tgt; m_bubble(i);
            end else if (!freeze) begin
                m_bubble(i);
            end
        end else begin
            if (branch_taken) begin
                if (!done) begin
                    m_pend[i] = 1'b1; m_kill[i] = m_pc[i];
                end
                m_pc[i] = tgt; m_bubble(i);
            end else if (done) begin
                if (freeze) begin
                    m_buf[i] = 1'b1; m_buf_i[i] = mem_word(m_pc[i]); m_buf_pc[i] = m_pc[i] + 32'd4;
                end else begin
                    m_val[i] = 1'b1; m_out_i[i] = mem_word(m_pc[i]); m_out_pc[i] = m_pc[i] + 32'd4;
                end
                m_pc[i] = m_pc[i] + 32'd4;
            end else if (!freeze) begin
                m_bubble(i);
            end
        end
    endtask

    // One clock: apply inputs, check the request against the model, advance, check IF/ID.
    task automatic step(input bit r, input bit fz, input bit br, input logic [31:0] ba, input bit rdy);
        rst = r; freeze = fz; branch_taken = br; branch_addr = ba; imem_ready = rdy;
        #1;
        for (int i = 0; i < NI; i++) begin
            bit exp_req;
            exp_req = !r && !m_buf[i];
            obs_req[i]  = imem_req[i];
            obs_addr[i] = imem_addr[i];
            chk($sformatf("dut%0d.imem_req", i), 32'(imem_req[i]), 32'(exp_req));
            if (exp_req)
                chk($sformatf("dut%0d.imem_addr", i), imem_addr[i], m_pend[i] ? m_kill[i] : m_pc[i]);
            model_step(i);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("dut%0d.valid_out", i), 32'(valid_out[i]), 32'(m_val[i]));
            chk($sformatf("dut%0d.instruction_out", i), instruction_out[i], m_out_i[i]);
            chk($sformatf("dut%0d.pc_out", i), pc_out[i], m_out_pc[i]);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; imem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state.
        do_reset();
        chk("lit_reset_valid", 32'(valid_out[0]), 32'h0);
        chk("lit_reset_pc_out", pc_out[0], 32'h0);
        chk("lit_reset_req", 32'(obs_req[0]), 32'h0);

        // Sequential fetch with zero-wait memory, plus reset-PC wrap on dut1.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_seq0_pc", pc_out[0], 32'h4);
        chk("lit_seq0_instr", instruction_out[0], 32'h100);
        chk("lit_wrap_pc", pc_out[1], 32'h0);
        chk("lit_wrap_instr", instruction_out[1], 32'h4000_00FF);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_seq1_pc", pc_out[0], 32'h8);
        chk("lit_seq1_instr", instruction_out[0], 32'h101);
        chk("lit_wrap_addr", obs_addr[1], 32'h0);

        // Wait states: two bubbles then the instruction.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("lit_wait_bubble", 32'(valid_out[0]), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_wait_pc", pc_out[0], 32'h4);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("lit_wait_addr", obs_addr[0], 32'h4);

        // Freeze on completion of addr 8.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("lit_frz_hold_pc", pc_out[0], 32'h8);
        chk("lit_frz_hold_instr", instruction_out[0], 32'h101);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("lit_frz_no_req", 32'(obs_req[0]), 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_frz_release_instr", instruction_out[0], 32'h102);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_frz_next_pc", pc_out[0], 32'h10);

        // Branch while the request to 0x10 is outstanding.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b0);
        chk("lit_br_bubble", 32'(valid_out[0]), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("lit_br_kill_addr", obs_addr[0], 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_br_drop", 32'(valid_out[0]), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_br_target_addr", obs_addr[0], 32'h200);
        chk("lit_br_target_pc", pc_out[0], 32'h204);
        chk("lit_br_target_instr", instruction_out[0], 32'h180);

        // Back-to-back branches, then freeze plus branch in HOLD.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_b2b_pc", pc_out[0], 32'h84);
        chk("lit_b2b_instr", instruction_out[0], 32'h120);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
        chk("lit_hold_br_bubble", 32'(valid_out[0]), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lit_hold_br_pc", pc_out[0], 32'h304);

        // Random traffic, including mid-stream resets.
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(9) < 3),
                 ($urandom_range(9) == 0),
                 $urandom(),
                 ($urandom_range(1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
